gat_layer_sequencer: RTL and testbench

Controller that sequences gat_top through NUM_LAYERS inference layers. Per layer it waits for the host to load the H-data, node-info and weight BRAMs, then strobes gat_layer and waits on gat_ready. It then drains the new-feature BRAM through port B into a valid/ready stream and reports per-layer cycle counts for the debug registers. It sits between the register bank / DMA and gat_top.

---
 rtl/gat_layer_sequencer_pkg.sv | 5 +
 rtl/gat_layer_sequencer_if.sv | 22 ++
 rtl/gat_layer_sequencer_feat_fifo.sv | 32 +++
 rtl/gat_layer_sequencer.sv | 122 ++++++++++++
 tb/tb_gat_layer_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/gat_layer_sequencer_pkg.sv
// gat_layer_sequencer_pkg: shared state encoding and feature FIFO sizing
package gat_layer_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_LOAD, KICK, WAIT_ACK, WAIT_DONE, DRAIN, DONE, ERR} state_t;
  localparam int FIFO_DEPTH = 4;
endpackage

// File: rtl/gat_layer_sequencer_if.sv
// gat_layer_sequencer_if: gat_top handshake, feature BRAM port B and drained feature stream
interface gat_layer_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic gat_layer;
  logic gat_ready;
  logic [ADDR_W+1:0] feat_bram_addrb;
  logic [DATA_W-1:0] feat_bram_dout;
  logic [DATA_W-1:0] m_feat_tdata;
  logic m_feat_tvalid;
  logic m_feat_tready;
  logic m_feat_tlast;
  modport master (
    output gat_layer, feat_bram_addrb, m_feat_tdata, m_feat_tvalid, m_feat_tlast,
    input gat_ready, feat_bram_dout, m_feat_tready
  );
  modport slave (
    input gat_layer, feat_bram_addrb, m_feat_tdata, m_feat_tvalid, m_feat_tlast,
    output gat_ready, feat_bram_dout, m_feat_tready
  );
endinterface

// File: rtl/gat_layer_sequencer_feat_fifo.sv
// gat_feat_fifo: small synchronous FIFO buffering feature words returned from the BRAM
module gat_feat_fifo
  import gat_layer_sequencer_pkg::*;
#(
  parameter int W = 32,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic [W-1:0] dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1;
      if (pop) rp <= rp + 1;
      count <= push == pop ? count : (push ? count + 1 : count - 1);
    end
  end
endmodule

// File: rtl/gat_layer_sequencer.sv
// gat_layer_sequencer: steps gat_top through its layers and drains each layer's features to a stream
module gat_layer_sequencer
  import gat_layer_sequencer_pkg::*;
#(
  parameter int NEW_FEATURE_WIDTH = 32,
  parameter int NEW_FEATURE_DEPTH = 43328,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int NUM_LAYERS = 2,
  parameter int BRAM_RD_LAT = 2,
  parameter int ACK_TIMEOUT = 64,
  parameter int TOP_WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic h_data_bram_load_done,
  input  logic h_node_info_bram_load_done,
  input  logic wgt_bram_load_done,
  gat_layer_sequencer_if.master bus,
  output logic [$clog2(NUM_LAYERS):0] layer_idx,
  output logic busy,
  output logic layer_done,
  output logic run_done,
  output logic err,
  output logic [TOP_WIDTH-1:0] cycle_cnt
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int LI = $clog2(NUM_LAYERS);
  localparam int AW = NEW_FEATURE_ADDR_W;
  localparam int TE = ACK_TIMEOUT - 1;
  localparam int LL = NUM_LAYERS - 1;
  localparam int LW = NEW_FEATURE_DEPTH - 1;
  localparam logic [TW-1:0] TMR_END = TE[TW-1:0];
  localparam logic [LI:0] LAST_LAYER = LL[LI:0];
  localparam logic [AW:0] DEPTH_W = NEW_FEATURE_DEPTH[AW:0];
  localparam logic [AW:0] LAST_W = LW[AW:0];
  state_t state;
  logic load_armed;
  logic [TW-1:0] ack_tmr;
  logic [AW:0] rd_addr, beat_cnt;
  logic [BRAM_RD_LAT-1:0] rd_vld;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
  logic [NEW_FEATURE_WIDTH-1:0] fifo_dout;
  logic [TOP_WIDTH-1:0] cnt_sat;
  logic rd_en, beat, last_beat, all_high, all_low;
  int pending;
  gat_feat_fifo #(.W(NEW_FEATURE_WIDTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(rd_vld[BRAM_RD_LAT-1]),
    .din(bus.feat_bram_dout),
    .pop(beat),
    .dout(fifo_dout),
    .count(fifo_count)
  );
  assign all_high = h_data_bram_load_done && h_node_info_bram_load_done && wgt_bram_load_done;
  assign all_low = !h_data_bram_load_done && !h_node_info_bram_load_done && !wgt_bram_load_done;
  assign pending = int'(fifo_count) + $countones(rd_vld);
  assign rd_en = state == DRAIN && rd_addr < DEPTH_W && pending < FIFO_DEPTH;
  assign cnt_sat = &cycle_cnt ? cycle_cnt : cycle_cnt + 1;
  assign bus.feat_bram_addrb = {rd_addr[AW-1:0], 2'b00};
  assign bus.m_feat_tvalid = fifo_count != '0;
  assign bus.m_feat_tdata = bus.m_feat_tvalid ? fifo_dout : '0;
  assign bus.m_feat_tlast = bus.m_feat_tvalid && beat_cnt == LAST_W;
  assign bus.gat_layer = state == KICK;
  assign beat = bus.m_feat_tvalid && bus.m_feat_tready;
  assign last_beat = beat && bus.m_feat_tlast;
  assign busy = !(state inside {IDLE, DONE, ERR});
  assign run_done = state == DONE;
  assign err = state == ERR;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      layer_idx <= '0;
      cycle_cnt <= '0;
      ack_tmr <= '0;
      rd_addr <= '0;
      beat_cnt <= '0;
      rd_vld <= '0;
      layer_done <= 1'b0;
      load_armed <= 1'b1;
    end else begin
      layer_done <= last_beat;
      load_armed <= last_beat ? 1'b0 : (all_low ? 1'b1 : load_armed);
      rd_vld <= BRAM_RD_LAT'({rd_vld, rd_en});
      if (rd_en) rd_addr <= rd_addr + 1;
      if (beat) beat_cnt <= beat_cnt + 1;
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state <= WAIT_LOAD;
          layer_idx <= '0;
        end
        WAIT_LOAD: if (all_high && load_armed) state <= KICK;
        KICK: begin
          cycle_cnt <= '0;
          ack_tmr <= TW'(1);
          rd_addr <= '0;
          beat_cnt <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          cycle_cnt <= cnt_sat;
          ack_tmr <= ack_tmr + 1;
          if (!bus.gat_ready) state <= WAIT_DONE;
          else if (ack_tmr == TMR_END) state <= ERR;
        end
        WAIT_DONE: begin
          cycle_cnt <= cnt_sat;
          if (bus.gat_ready) state <= DRAIN;
        end
        DRAIN: if (last_beat) begin
          if (layer_idx == LAST_LAYER) state <= DONE;
          else begin
            layer_idx <= layer_idx + 1;
            state <= WAIT_LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gat_layer_sequencer.sv
// tb_gat_layer_sequencer: directed run sequence with random stream back-pressure against a word-order model
module tb_gat_layer_sequencer;
  localparam int DW = 32;
  localparam int DEPTH = 64;
  localparam int AW = 6;
  localparam int NL = 2;
  localparam int LAT = 2;
  localparam int ACK = 64;
  localparam int TW = 8;
  logic clk = 1'b0;
  logic rst_n, start, h_data, h_node, wgt;
  logic [$clog2(NL):0] layer_idx;
  logic busy, layer_done, run_done, err;
  logic [TW-1:0] cycle_cnt;
  logic [DW-1:0] salt;
  logic [AW-1:0] a1;
  int checks = 0;
  int errors = 0;
  gat_layer_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  gat_layer_sequencer #(
    .NEW_FEATURE_WIDTH(DW), .NEW_FEATURE_DEPTH(DEPTH), .NEW_FEATURE_ADDR_W(AW),
    .NUM_LAYERS(NL), .BRAM_RD_LAT(LAT), .ACK_TIMEOUT(ACK), .TOP_WIDTH(TW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .h_data_bram_load_done(h_data),
    .h_node_info_bram_load_done(h_node),
    .wgt_bram_load_done(wgt),
    .bus(bus),
    .layer_idx(layer_idx),
    .busy(busy),
    .layer_done(layer_done),
    .run_done(run_done),
    .err(err),
    .cycle_cnt(cycle_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    a1 <= bus.feat_bram_addrb[AW+1:2];
    bus.feat_bram_dout <= salt ^ DW'(a1);
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_flags(input logic v);
    h_data = v;
    h_node = v;
    wgt = v;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic chk_all_zero(input string tag);
    chk(tag, 64'({bus.gat_layer, bus.feat_bram_addrb, bus.m_feat_tdata, bus.m_feat_tvalid,
      bus.m_feat_tlast, layer_idx, busy, layer_done, run_done, err, cycle_cnt}), 64'd0);
  endtask
  task automatic do_layer(input int lyr, input int pct, input int comp, input bit start_mid,
                          input bit drop_mid, input bit keep, input int abort_at);
    int idx, exp_cc;
    bit kicked;
    salt = $urandom;
    exp_cc = (3 + comp > 255) ? 255 : 3 + comp;
    @(posedge clk);
    #1 set_flags(1'b1);
    kicked = 1'b0;
    for (int i = 0; i < 40 && !kicked; i++) begin
      @(negedge clk);
      kicked = bus.gat_layer;
    end
    chk("kick_seen", 64'(kicked), 64'd1);
    if (!kicked) return;
    @(posedge clk);
    @(negedge clk);
    chk("kick_one_cycle", 64'(bus.gat_layer), 64'd0);
    chk("busy_compute", 64'(busy), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1 bus.gat_ready = 1'b0;
    for (int i = 0; i < comp; i++) begin
      @(posedge clk);
      #1 start = start_mid && i == 10;
    end
    bus.gat_ready = 1'b1;
    @(negedge clk);
    chk("busy_wait_done", 64'(busy), 64'd1);
    chk("idx_wait_done", 64'(layer_idx), 64'(lyr));
    idx = 0;
    for (int c = 0; c < 3000 && idx < DEPTH && idx != abort_at; c++) begin
      @(posedge clk);
      #1 bus.m_feat_tready = $urandom_range(99) < pct;
      if (drop_mid) bus.gat_ready = !(c >= 5 && c < 9);
      @(negedge clk);
      if (bus.m_feat_tvalid) begin
        chk("tdata", 64'(bus.m_feat_tdata), 64'(salt ^ DW'(idx)));
        chk("tlast", 64'(bus.m_feat_tlast), 64'(idx == DEPTH - 1));
        if (bus.m_feat_tready) idx++;
      end
    end
    if (abort_at >= 0) return;
    chk("drain_words", 64'(idx), 64'(DEPTH));
    @(posedge clk);
    #1 bus.m_feat_tready = 1'b0;
    @(negedge clk);
    chk("layer_done", 64'(layer_done), 64'd1);
    chk("cycle_cnt", 64'(cycle_cnt), 64'(exp_cc));
    chk("layer_idx_next", 64'(layer_idx), 64'(lyr == NL - 1 ? lyr : lyr + 1));
    chk("run_done_lvl", 64'(run_done), 64'(lyr == NL - 1));
    chk("no_extra_beat", 64'(bus.m_feat_tvalid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("layer_done_pulse", 64'(layer_done), 64'd0);
    if (!keep) begin
      @(posedge clk);
      #1 set_flags(1'b0);
    end
  endtask
  initial begin
    int kicks;
    bit kicked;
    rst_n = 1'b0;
    start = 1'b0;
    set_flags(1'b0);
    salt = '0;
    bus.gat_ready = 1'b1;
    bus.m_feat_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_outs");
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulse_start();
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'd1);
    do_layer(0, 100, 100, 1'b0, 1'b0, 1'b0, -1);
    do_layer(1, 100, 100, 1'b0, 1'b0, 1'b0, -1);
    @(negedge clk);
    chk("run_done_hold", 64'(run_done), 64'd1);
    chk("busy_done", 64'(busy), 64'd0);
    @(posedge clk);
    #1 pulse_start();
    @(negedge clk);
    chk("run_done_cleared", 64'(run_done), 64'd0);
    chk("busy_restart", 64'(busy), 64'd1);
    do_layer(0, 30, 100, 1'b0, 1'b1, 1'b1, -1);
    kicks = 0;
    repeat (20) begin
      @(negedge clk);
      kicks += int'(bus.gat_layer);
    end
    chk("stale_flags_no_kick", 64'(kicks), 64'd0);
    @(posedge clk);
    #1 set_flags(1'b0);
    do_layer(1, 30, 300, 1'b1, 1'b0, 1'b0, -1);
    @(posedge clk);
    #1 set_flags(1'b1);
    pulse_start();
    kicked = 1'b0;
    for (int i = 0; i < 40 && !kicked; i++) begin
      @(negedge clk);
      kicked = bus.gat_layer;
    end
    chk("timeout_kick", 64'(kicked), 64'd1);
    repeat (ACK - 1) @(negedge clk);
    chk("err_not_early", 64'(err), 64'd0);
    @(negedge clk);
    chk("err_timeout", 64'(err), 64'd1);
    chk("busy_err", 64'(busy), 64'd0);
    @(posedge clk);
    #1 pulse_start();
    @(negedge clk);
    chk("err_cleared", 64'(err), 64'd0);
    chk("busy_recover", 64'(busy), 64'd1);
    do_layer(0, 100, 50, 1'b0, 1'b0, 1'b0, 40);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.m_feat_tready = 1'b0;
    @(negedge clk);
    chk_all_zero("abort_outs");
    @(posedge clk);
    #1 pulse_start();
    do_layer(0, 100, 20, 1'b0, 1'b0, 1'b0, -1);
    do_layer(1, 60, 20, 1'b0, 1'b0, 1'b0, -1);
    @(negedge clk);
    chk("final_run_done", 64'(run_done), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
